// File: rtl/ahb_qspi_xip_reader.sv
// AHB-Lite execute-in-place reader: turns word reads into Quad I/O Fast Read (0xEB)
// flash transactions, with a one-word buffer that answers repeat fetches at zero wait.
module ahb_qspi_xip_reader #(
  parameter int DUMMY_CYCLES   = 4,
  parameter int CS_HIGH_CYCLES = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  input  logic [3:0]  fdi,
  output logic [3:0]  fdo,
  output logic        fdoe,
  output logic        fsclk,
  output logic        fcen
);

  typedef enum logic [2:0] {
    StIdle, StCsWait, StCmd, StAddr, StMode, StDummy, StData
  } state_t;

  localparam logic [7:0] CmdByte   = 8'hEB;
  localparam logic [3:0] DummyLast = 4'(DUMMY_CYCLES - 1);
  localparam logic [3:0] CsHigh    = 4'(CS_HIGH_CYCLES);

  state_t      state_q;
  logic        phase_q;
  logic [3:0]  cnt_q;
  logic [21:0] addr_q;
  logic [21:0] tag_q;
  logic        valid_q;
  logic [31:0] dataSh_q;
  logic [31:0] hrdata_q;
  logic        hreadyout_q;
  logic        hresp_q;
  logic        errPend_q;
  logic        fcen_q;
  logic        fsclk_q;
  logic [3:0]  fdo_q;
  logic        fdoe_q;
  logic [3:0]  csCnt_q;

  logic        accept;
  logic        hit;
  logic        csOk;
  logic        startCmd;
  logic [3:0]  lastCnt;
  logic [3:0]  cntInc;
  state_t      nextState;
  logic [4:0]  nibPos;
  logic [31:0] dataSh_d;
  logic        unusedBits;

  function automatic logic [3:0] fdoFor(input state_t st, input logic [2:0] cnt,
                                        input logic [21:0] wordAddr);
    logic [23:0] a;
    logic [3:0]  v;
    a = {wordAddr, 2'b00};
    v = 4'h0;
    case (st)
      StCmd:   v = {3'b110, CmdByte[3'd7 - cnt]};
      StAddr: begin
        case (cnt)
          3'd0:    v = a[23:20];
          3'd1:    v = a[19:16];
          3'd2:    v = a[15:12];
          3'd3:    v = a[11:8];
          3'd4:    v = a[7:4];
          default: v = a[3:0];
        endcase
      end
      default: v = 4'h0;
    endcase
    return v;
  endfunction

  function automatic logic fdoeFor(input state_t st);
    return (st == StCmd) || (st == StAddr) || (st == StMode);
  endfunction

  assign unusedBits = ^{HSIZE, HADDR[31:24], HADDR[1:0]};

  // Nibble k of the flash stream lands in byte k/2, high nibble first.
  always_comb begin
    accept   = HSEL & HREADY & HTRANS[1] & hreadyout_q;
    hit      = valid_q && (tag_q == HADDR[23:2]);
    csOk     = (csCnt_q >= CsHigh);
    cntInc   = cnt_q + 4'd1;
    nibPos   = {cnt_q[2:1], ~cnt_q[0], 2'b00};
    dataSh_d = dataSh_q;
    dataSh_d[nibPos +: 4] = fdi;
    startCmd = ((state_q == StIdle) && accept && !HWRITE && !hit && csOk) ||
               ((state_q == StCsWait) && csOk);
    lastCnt   = 4'd0;
    nextState = StIdle;
    case (state_q)
      StCmd:   begin lastCnt = 4'd7;      nextState = StAddr;  end
      StAddr:  begin lastCnt = 4'd5;      nextState = StMode;  end
      StMode:  begin lastCnt = 4'd1;      nextState = StDummy; end
      StDummy: begin lastCnt = DummyLast; nextState = StData;  end
      StData:  begin lastCnt = 4'd7;      nextState = StIdle;  end
      default: begin lastCnt = 4'd0;      nextState = StIdle;  end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      phase_q     <= 1'b0;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      dataSh_q    <= '0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      errPend_q   <= 1'b0;
      fcen_q      <= 1'b1;
      fsclk_q     <= 1'b0;
      fdo_q       <= 4'h0;
      fdoe_q      <= 1'b0;
      csCnt_q     <= 4'hF;
    end else begin
      if (fcen_q && (csCnt_q != 4'hF)) csCnt_q <= csCnt_q + 4'd1;
      // Two-cycle ERROR: first cycle stalls, second releases with HRESP still high.
      if (errPend_q) begin
        hreadyout_q <= 1'b1;
        errPend_q   <= 1'b0;
      end else if (hresp_q) begin
        hresp_q <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (accept && HWRITE) begin
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
            errPend_q   <= 1'b1;
          end else if (accept && !hit) begin
            addr_q      <= HADDR[23:2];
            hreadyout_q <= 1'b0;
            if (!csOk) state_q <= StCsWait;
          end
        end
        StCsWait: ;
        default: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
            fsclk_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            fsclk_q <= 1'b0;
            if (state_q == StData) dataSh_q <= dataSh_d;
            if (cnt_q == lastCnt) begin
              cnt_q <= 4'd0;
              if (state_q == StData) begin
                state_q     <= StIdle;
                fcen_q      <= 1'b1;
                fdoe_q      <= 1'b0;
                fdo_q       <= 4'h0;
                hrdata_q    <= dataSh_d;
                tag_q       <= addr_q;
                valid_q     <= 1'b1;
                hreadyout_q <= 1'b1;
                hresp_q     <= 1'b0;
                csCnt_q     <= 4'd1;
              end else begin
                state_q <= nextState;
                fdo_q   <= fdoFor(nextState, 3'd0, addr_q);
                fdoe_q  <= fdoeFor(nextState);
              end
            end else begin
              cnt_q <= cntInc;
              fdo_q <= fdoFor(state_q, cntInc[2:0], addr_q);
            end
          end
        end
      endcase
      if (startCmd) begin
        state_q <= StCmd;
        phase_q <= 1'b0;
        cnt_q   <= 4'd0;
        fcen_q  <= 1'b0;
        fsclk_q <= 1'b0;
        fdoe_q  <= 1'b1;
        fdo_q   <= {3'b110, CmdByte[7]};
      end
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign fdo       = fdo_q;
  assign fdoe      = fdoe_q;
  assign fsclk     = fsclk_q;
  assign fcen      = fcen_q;

endmodule

// File: tb/tb_ahb_qspi_xip_reader.sv
// Bench for ahb_qspi_xip_reader: two builds (4 and 8 dummy clocks) share the bus,
// each attached to a behavioural quad-SPI flash; reads are scored against a queue.
module tb_ahb_qspi_xip_reader;

  localparam int Dum0   = 4;
  localparam int Dum1   = 8;
  localparam int CsHigh = 2;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel [2];
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic        hready;
  logic        hro [2];
  logic        hresp [2];
  logic [31:0] hrdata [2];
  logic [3:0]  fdo [2];
  logic [3:0]  fdi [2];
  logic        fdoe [2];
  logic        fsclk [2];
  logic        fcen [2];
  int          cur;
  int          tests;
  int          failed;

  int          sck [2];
  int          falls [2];
  int          pinErr [2];
  int          hiCnt [2];
  int          lastHigh [2];
  bit          prevCen [2];
  bit          prevSck [2];
  logic [7:0]  cmdRx [2];
  logic [23:0] adrRx [2];

  typedef struct {
    logic [31:0] addr;
    bit          write;
    bit          miss;
    int          expWait;
    bit          expResp;
  } vec_t;

  typedef struct {
    int          inst;
    logic [31:0] addr;
    bit          write;
    bit          miss;
    int          expWait;
    bit          expResp;
    logic [31:0] expData;
  } exp_t;

  vec_t vecs [10];
  exp_t sbq [$];

  always #5 HCLK = ~HCLK;
  assign hready = (cur == 1) ? hro[1] : hro[0];

  ahb_qspi_xip_reader #(.DUMMY_CYCLES(Dum0), .CS_HIGH_CYCLES(CsHigh)) u0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(3'b010), .HREADY(hready), .HREADYOUT(hro[0]),
    .HRESP(hresp[0]), .HRDATA(hrdata[0]), .fdi(fdi[0]), .fdo(fdo[0]), .fdoe(fdoe[0]),
    .fsclk(fsclk[0]), .fcen(fcen[0])
  );

  ahb_qspi_xip_reader #(.DUMMY_CYCLES(Dum1), .CS_HIGH_CYCLES(CsHigh)) u1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(3'b010), .HREADY(hready), .HREADYOUT(hro[1]),
    .HRESP(hresp[1]), .HRDATA(hrdata[1]), .fdi(fdi[1]), .fdo(fdo[1]), .fdoe(fdoe[1]),
    .fsclk(fsclk[1]), .fcen(fcen[1])
  );

  function automatic int dumFor(input int g);
    return (g == 0) ? Dum0 : Dum1;
  endfunction

  function automatic logic [7:0] memByte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      default:    return (a[7:0] ^ 8'h5A) + a[15:8] + a[23:16];
    endcase
  endfunction

  function automatic logic [31:0] wordAt(input logic [23:0] a);
    logic [23:0] b;
    b = {a[23:2], 2'b00};
    return {memByte(b + 24'd3), memByte(b + 24'd2), memByte(b + 24'd1), memByte(b)};
  endfunction

  function automatic logic [3:0] nibbleAt(input logic [23:0] a, input int k);
    logic [7:0] by;
    by = memByte(a + 24'(k / 2));
    return (k % 2 == 0) ? by[7:4] : by[3:0];
  endfunction

  // Flash model, observed mid-cycle; data is presented during the SCK-high phase.
  always @(negedge HCLK) begin
    int n;
    int d;
    for (int g = 0; g < 2; g++) begin
      d = dumFor(g);
      if (!HRESETn) begin
        sck[g] = 0;
        fdi[g] = 4'h0;
      end else begin
        if (fcen[g] && !prevCen[g] && sck[g] != 24 + d) pinErr[g]++;
        if (!fcen[g] && prevCen[g]) begin
          falls[g]++;
          lastHigh[g] = hiCnt[g];
          sck[g] = 0;
        end
        if (!fcen[g] && fsclk[g] && !prevSck[g]) begin
          n = sck[g];
          if (n < 8) begin
            cmdRx[g] = {cmdRx[g][6:0], fdo[g][0]};
            if (fdo[g][3:1] != 3'b110 || !fdoe[g]) pinErr[g]++;
          end else if (n < 14) begin
            adrRx[g] = {adrRx[g][19:0], fdo[g]};
            if (!fdoe[g]) pinErr[g]++;
          end else if (n < 16) begin
            if (fdo[g] != 4'h0 || !fdoe[g]) pinErr[g]++;
          end else if (n < 16 + d) begin
            if (fdoe[g]) pinErr[g]++;
          end else if (n < 24 + d) begin
            if (fdoe[g]) pinErr[g]++;
            fdi[g] = nibbleAt(adrRx[g], n - 16 - d);
          end else begin
            pinErr[g]++;
          end
          sck[g] = n + 1;
        end
      end
      if (fcen[g]) hiCnt[g]++;
      else hiCnt[g] = 0;
      prevCen[g] = fcen[g];
      prevSck[g] = fsclk[g];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic checkOutput(input int waits, input logic firstResp, input int fallsBefore);
    exp_t e;
    int   g;
    if (sbq.size() == 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL scoreboard: got 0 queued entries, required 1");
      return;
    end
    e = sbq.pop_front();
    g = e.inst;
    chk("waitStates", 32'(waits), 32'(e.expWait));
    chk("respFirst", 32'(firstResp), 32'(e.expResp));
    chk("respLast", 32'(hresp[g]), 32'(e.expResp));
    if (!e.write) chk("rdata", hrdata[g], e.expData);
    chk("flashTxns", 32'(falls[g] - fallsBefore), e.miss ? 32'd1 : 32'd0);
    if (e.miss) begin
      chk("cmdByte", 32'(cmdRx[g]), 32'h000000EB);
      chk("flashAddr", 32'(adrRx[g]), 32'({e.addr[23:2], 2'b00}));
      chk("csHighGap", 32'(lastHigh[g] >= CsHigh), 32'd1);
    end
    chk("pinProtocol", 32'(pinErr[g]), 32'd0);
  endtask

  task automatic applyStimulus(input int inst, input logic [31:0] addr, input bit write,
                               input bit miss, input int expWait, input bit expResp);
    exp_t e;
    int   waits;
    int   fallsBefore;
    logic firstResp;
    e = '{inst, addr, write, miss, expWait, expResp, wordAt(addr[23:0])};
    sbq.push_back(e);
    fallsBefore = falls[inst];
    cur = inst;
    hsel[inst] = 1'b1;
    haddr = addr;
    htrans = 2'b10;
    hwrite = write;
    @(posedge HCLK);
    @(negedge HCLK);
    hsel[inst] = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    firstResp = hresp[inst];
    waits = 0;
    while (!hro[inst] && waits < 300) begin
      waits++;
      @(negedge HCLK);
    end
    checkOutput(waits, firstResp, fallsBefore);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, required finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fb;
    tests = 0;
    failed = 0;
    HRESETn = 1'b0;
    hsel[0] = 1'b0;
    hsel[1] = 1'b0;
    haddr = '0;
    htrans = 2'b00;
    hwrite = 1'b0;
    cur = 0;

    vecs[0] = '{32'h0000_0100, 1'b0, 1'b1, 56, 1'b0};
    vecs[1] = '{32'h0000_0100, 1'b0, 1'b0, 0,  1'b0};
    vecs[2] = '{32'h0000_0104, 1'b0, 1'b1, 56, 1'b0};
    vecs[3] = '{32'h0000_0108, 1'b0, 1'b1, 57, 1'b0};
    vecs[4] = '{32'h0000_0104, 1'b0, 1'b1, 57, 1'b0};
    vecs[5] = '{32'h0000_0108, 1'b0, 1'b1, 57, 1'b0};
    vecs[6] = '{32'h0000_0000, 1'b1, 1'b0, 1,  1'b1};
    vecs[7] = '{32'h0000_0108, 1'b0, 1'b0, 0,  1'b0};
    vecs[8] = '{32'h00FF_FFFC, 1'b0, 1'b1, 56, 1'b0};
    vecs[9] = '{32'hABFF_FFFC, 1'b0, 1'b0, 0,  1'b0};

    repeat (3) @(negedge HCLK);
    for (int g = 0; g < 2; g++) begin
      chk("rstHreadyout", 32'(hro[g]), 32'd1);
      chk("rstHresp", 32'(hresp[g]), 32'd0);
      chk("rstHrdata", hrdata[g], 32'd0);
      chk("rstFcen", 32'(fcen[g]), 32'd1);
      chk("rstFsclk", 32'(fsclk[g]), 32'd0);
      chk("rstFdoe", 32'(fdoe[g]), 32'd0);
      chk("rstFdo", 32'(fdo[g]), 32'd0);
    end
    HRESETn = 1'b1;
    @(negedge HCLK);

    for (int i = 0; i < 10; i++)
      applyStimulus(0, vecs[i].addr, vecs[i].write, vecs[i].miss, vecs[i].expWait,
                    vecs[i].expResp);

    // IDLE and BUSY transfers, and an unselected NONSEQ, must leave everything alone.
    fb = falls[0];
    hsel[0] = 1'b1;
    haddr = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      htrans = (i < 2) ? 2'b00 : 2'b01;
      @(negedge HCLK);
      chk("idleReady", 32'(hro[0]), 32'd1);
      chk("idleResp", 32'(hresp[0]), 32'd0);
    end
    hsel[0] = 1'b0;
    htrans = 2'b10;
    @(negedge HCLK);
    chk("unselReady", 32'(hro[0]), 32'd1);
    htrans = 2'b00;
    @(negedge HCLK);
    chk("idleNoFlash", 32'(falls[0] - fb), 32'd0);
    applyStimulus(0, 32'h00FF_FFFC, 1'b0, 1'b0, 0, 1'b0);

    // Reset pulsed in the middle of a miss.
    cur = 0;
    hsel[0] = 1'b1;
    haddr = 32'h0000_010C;
    htrans = 2'b10;
    @(posedge HCLK);
    @(negedge HCLK);
    hsel[0] = 1'b0;
    htrans = 2'b00;
    repeat (19) @(negedge HCLK);
    chk("midMissCen", 32'(fcen[0]), 32'd0);
    chk("midMissReady", 32'(hro[0]), 32'd0);
    #1 HRESETn = 1'b0;
    #1;
    chk("abortFcen", 32'(fcen[0]), 32'd1);
    chk("abortFdoe", 32'(fdoe[0]), 32'd0);
    chk("abortFsclk", 32'(fsclk[0]), 32'd0);
    chk("abortReady", 32'(hro[0]), 32'd1);
    chk("abortHrdata", hrdata[0], 32'd0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    applyStimulus(0, 32'h0000_0108, 1'b0, 1'b1, 56, 1'b0);
    applyStimulus(0, 32'h0000_0108, 1'b0, 1'b0, 0, 1'b0);

    // Eight dummy clocks at the top of the flash.
    applyStimulus(1, 32'h00FF_FFFC, 1'b0, 1'b1, 64, 1'b0);
    applyStimulus(1, 32'h00FF_FFFC, 1'b0, 1'b0, 0, 1'b0);

    chk("sbDrained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
